// File: rtl/dsp_pkg.sv
// Shared definitions for the sequenced multiply-accumulate block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default accumulator width, operand-to-result
//           pipeline depth.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ACC_WIDTH_DEF = 48;

  // Edges from the last accepted beat to out_valid: operand reg, product reg,
  // accumulate.
  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/dsp_pipe_stage.sv
// Generic pipeline register with clock enable and synchronous clear.
// Latency: 1 cycle when i_ce is high.
// Backpressure: none, holds its value while i_ce is low.
// Ports: i_clk clock, i_rst sync active-high clear, i_ce load enable,
//        i_d data in, o_q registered data out.
module dsp_pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// Frame-based signed multiply-accumulate: sums a*b over len beats per frame.
// Latency: out_valid rises 3 edges after the edge accepting the last beat.
// Backpressure: in_ready only in LOAD; result held in DONE until out_ready.
// Ports: clk, RST (sync active-high); start/len frame request; in_valid,
//        in_ready, a, b operand stream; out_valid, out_ready, result,
//        overflow frame result; busy high outside IDLE.
module dsp_mac_seq
  import dsp_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PW  = 2 * WIDTH;
  localparam int EXT = ACC_WIDTH - PW;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_ovf;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic                   r_v1;
  logic                   r_v2;
  // Marks the final beat as it moves through the three pipeline stages.
  logic [PIPE_LAT-1:0]    r_last;

  logic                   w_accept;
  logic                   w_last_beat;
  logic [PW-1:0]          w_ops;
  logic [WIDTH-1:0]       w_a_q;
  logic [WIDTH-1:0]       w_b_q;
  logic [PW-1:0]          w_a_ext;
  logic [PW-1:0]          w_b_ext;
  logic [PW-1:0]          w_prod;
  logic [PW-1:0]          w_prod_q;
  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_ovf_add;

  assign w_accept    = in_valid & r_in_ready;
  assign w_last_beat = w_accept & (r_cnt == LEN_WIDTH'(1));

  // Stage 1: operand pair.
  dsp_pipe_stage #(.WIDTH(PW)) u_op_stage (
    .i_clk (clk),
    .i_rst (RST),
    .i_ce  (w_accept),
    .i_d   ({a, b}),
    .o_q   (w_ops)
  );

  assign w_a_q = w_ops[PW-1:WIDTH];
  assign w_b_q = w_ops[WIDTH-1:0];

  // Sign-extending both operands to the product width makes the low PW bits
  // of a plain multiply equal to the signed product.
  assign w_a_ext = {{WIDTH{w_a_q[WIDTH-1]}}, w_a_q};
  assign w_b_ext = {{WIDTH{w_b_q[WIDTH-1]}}, w_b_q};
  assign w_prod  = w_a_ext * w_b_ext;

  // Stage 2: full-width signed product.
  dsp_pipe_stage #(.WIDTH(PW)) u_prod_stage (
    .i_clk (clk),
    .i_rst (RST),
    .i_ce  (r_v1),
    .i_d   (w_prod),
    .o_q   (w_prod_q)
  );

  // Stage 3 arithmetic: wrapping add, overflow when like-signed operands
  // produce a sum of the opposite sign.
  assign w_prod_ext = {{EXT{w_prod_q[PW-1]}}, w_prod_q};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_ovf_add  = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_last      <= '0;
    end else begin
      // The pipeline never stalls internally, so latency after the last
      // accepted beat is fixed regardless of input gaps.
      r_v1   <= w_accept;
      r_v2   <= r_v1;
      r_last <= {r_last[PIPE_LAT-2:0], w_last_beat};

      if (r_v2) begin
        r_acc <= w_sum;
        if (w_ovf_add) begin
          r_ovf <= 1'b1;
        end
      end

      if (w_accept) begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_cnt      <= len;
              r_in_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (w_last_beat) begin
            r_in_ready <= 1'b0;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_last[PIPE_LAT-1]) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overflow  = r_ovf;
  assign result    = r_acc;

endmodule

// File: tb/tb_dsp_mac_seq.sv
module tb_dsp_mac_seq;

  localparam int W  = 18;
  localparam int AW = 48;
  localparam int LW = 16;
  localparam longint HALF = 64'sd140737488355328;  // 2^47
  localparam longint FULL = 64'sd281474976710656;  // 2^48

  logic          clk = 1'b0;
  logic          RST;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;
  logic          busy;
  logic          overflow;

  dsp_mac_seq #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Operands of the frame being driven; the model reads the same lists.
  longint qa[$];
  longint qb[$];

  // Observations from the last frame.
  logic [AW-1:0] o_res;
  logic          o_ovf;
  int            o_lat;
  bit            o_held;
  bit            o_idle;
  bit            o_busy;
  bit            o_rdy_ok;

  logic [AW-1:0] e_res;
  logic          e_ovf;

  // Reference: exact integer sum, folded back into the signed 48-bit range
  // whenever it leaves it (each fold is one overflow event).
  function automatic void model(output logic [AW-1:0] r, output logic ov);
    longint s = 0;
    ov = 1'b0;
    foreach (qa[i]) begin
      s = s + qa[i] * qb[i];
      if (s >= HALF) begin
        s  = s - FULL;
        ov = 1'b1;
      end else if (s < -HALF) begin
        s  = s + FULL;
        ov = 1'b1;
      end
    end
    r = AW'(s);
  endfunction

  function automatic longint rnd_op();
    return longint'($urandom_range(0, 262143)) - 64'sd131072;
  endfunction

  // Runs one frame of qa.size() beats (n may be 0). Inputs are driven and
  // outputs sampled 1 time unit after the rising edge.
  task automatic do_frame(input int gap_min, input int gap_max, input int stall,
                          input bit pulse_start);
    int  n;
    int  t;
    int  k;
    bit  to;
    n        = qa.size();
    to       = 1'b0;
    o_held   = 1'b1;
    o_busy   = 1'b1;
    o_rdy_ok = 1'b1;
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = LW'($urandom);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (!busy) o_busy = 1'b0;
      end
      in_valid = 1'b1;
      a = W'(qa[i]);
      b = W'(qb[i]);
      if (pulse_start && i == 1) begin
        start = 1'b1;
        len   = LW'(9);
      end
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 20) to = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      len      = LW'($urandom);
      if (!busy) o_busy = 1'b0;
    end
    if (n == 0 && in_ready) o_rdy_ok = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!busy) o_busy = 1'b0;
      if (n == 0 && in_ready) o_rdy_ok = 1'b0;
    end
    o_lat = (k >= 40 || to) ? -1 : k;
    o_res = result;
    o_ovf = overflow;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!out_valid || result !== o_res || overflow !== o_ovf) o_held = 1'b0;
      if (n == 0 && in_ready) o_rdy_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    o_idle = !out_valid && !busy && !in_ready;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy/rdy/vld/ovf=%b expected 0000",
               {busy, in_ready, out_valid, overflow});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result got %0d expected 0", result);
    end
  endtask

  task automatic test_basic();
    qa = '{2, 4, -1};
    qb = '{3, 5, 7};
    model(e_res, e_ovf);
    do_frame(0, 0, 0, 1'b0);
    checks++;
    if (o_res !== e_res) begin
      errors++;
      $display("FAIL basic_result got %0d expected %0d", $signed(o_res), $signed(e_res));
    end
    checks++;
    if (o_ovf !== e_ovf) begin
      errors++;
      $display("FAIL basic_overflow got %b expected %b", o_ovf, e_ovf);
    end
    checks++;
    if (o_lat !== 3) begin
      errors++;
      $display("FAIL basic_latency got %0d expected 3", o_lat);
    end
    checks++;
    if ({o_busy, o_idle} !== 2'b11) begin
      errors++;
      $display("FAIL basic_busy_idle got %b expected 11", {o_busy, o_idle});
    end
  endtask

  task automatic test_len_zero();
    qa.delete();
    qb.delete();
    do_frame(0, 0, 2, 1'b0);
    checks++;
    if (o_lat !== 0) begin
      errors++;
      $display("FAIL len0_latency got %0d edges expected 0 after start edge", o_lat);
    end
    checks++;
    if (o_res !== '0) begin
      errors++;
      $display("FAIL len0_result got %0d expected 0", o_res);
    end
    checks++;
    if ({o_rdy_ok, o_idle} !== 2'b11) begin
      errors++;
      $display("FAIL len0_ready_idle got %b expected 11", {o_rdy_ok, o_idle});
    end
  endtask

  task automatic test_backpressure();
    qa = '{131071, -131072};
    qb = '{131071, 1};
    model(e_res, e_ovf);
    do_frame(1, 1, 5, 1'b0);
    checks++;
    if (o_res !== e_res) begin
      errors++;
      $display("FAIL bp_result got %0d expected %0d", $signed(o_res), $signed(e_res));
    end
    checks++;
    if (o_lat !== 3) begin
      errors++;
      $display("FAIL bp_latency got %0d expected 3", o_lat);
    end
    checks++;
    if ({o_held, o_idle} !== 2'b11) begin
      errors++;
      $display("FAIL bp_held_idle got %b expected 11", {o_held, o_idle});
    end
  endtask

  task automatic test_overflow();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 8192; i++) begin
      qa.push_back(-131072);
      qb.push_back(-131072);
    end
    model(e_res, e_ovf);
    do_frame(0, 0, 0, 1'b0);
    checks++;
    if (o_res !== e_res) begin
      errors++;
      $display("FAIL ovf_result got %0d expected %0d", $signed(o_res), $signed(e_res));
    end
    checks++;
    if (o_ovf !== e_ovf) begin
      errors++;
      $display("FAIL ovf_flag got %b expected %b", o_ovf, e_ovf);
    end
    qa = '{1};
    qb = '{1};
    model(e_res, e_ovf);
    do_frame(0, 0, 0, 1'b0);
    checks++;
    if ({o_ovf, o_res} !== {e_ovf, e_res}) begin
      errors++;
      $display("FAIL ovf_next_frame got ovf=%b res=%0d expected ovf=%b res=%0d",
               o_ovf, $signed(o_res), e_ovf, $signed(e_res));
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    len   = LW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = W'(rnd_op());
      b = W'(rnd_op());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_flags got busy/rdy/vld/ovf=%b expected 0000",
               {busy, in_ready, out_valid, overflow});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL midrst_result got %0d expected 0", result);
    end
    qa = '{5};
    qb = '{-6};
    model(e_res, e_ovf);
    do_frame(0, 0, 0, 1'b0);
    checks++;
    if (o_res !== e_res) begin
      errors++;
      $display("FAIL midrst_new_frame got %0d expected %0d", $signed(o_res), $signed(e_res));
    end
  endtask

  task automatic test_start_ignored();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 5; i++) begin
      qa.push_back(rnd_op());
      qb.push_back(rnd_op());
    end
    model(e_res, e_ovf);
    do_frame(0, 2, 1, 1'b1);
    checks++;
    if (o_res !== e_res) begin
      errors++;
      $display("FAIL start_ign_result got %0d expected %0d", $signed(o_res), $signed(e_res));
    end
    checks++;
    if ({o_lat == 3, o_idle} !== 2'b11) begin
      errors++;
      $display("FAIL start_ign_lat_idle got lat=%0d idle=%b expected lat=3 idle=1",
               o_lat, o_idle);
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 16);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(rnd_op());
        qb.push_back(rnd_op());
      end
      model(e_res, e_ovf);
      do_frame(0, 3, $urandom_range(0, 4), 1'b0);
      checks++;
      if ({o_ovf, o_res} !== {e_ovf, e_res}) begin
        errors++;
        $display("FAIL rand%0d_result got ovf=%b res=%0d expected ovf=%b res=%0d",
                 f, o_ovf, $signed(o_res), e_ovf, $signed(e_res));
      end
      checks++;
      if (o_lat !== 3) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d expected 3", f, o_lat);
      end
      checks++;
      if ({o_held, o_idle, o_busy} !== 3'b111) begin
        errors++;
        $display("FAIL rand%0d_held_idle_busy got %b expected 111", f,
                 {o_held, o_idle, o_busy});
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
